sine_period_detector: RTL and testbench

- Receive-side counterpart of the transmit sine generator: consumes 8-bit offset-binary sine samples from the ADC/loopback path.
- Detects rising mid-level crossings with hysteresis and measures samples-per-cycle (period) and peak-to-peak amplitude per cycle.
- Flags lock or loss of signal to the demodulator and experiment control logic.

---
 rtl/sine_period_detector.sv | 131 +++++++++++++
 tb/tb_sine_period_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_period_detector.sv
// Rising mid-level crossing detector with hysteresis for 8-bit offset-binary
// sine samples; reports period and peak-to-peak amplitude per cycle.
module sine_period_detector #(
   parameter logic [7:0] MID        = 8'h50,
   parameter logic [7:0] HYST       = 8'h08,
   parameter int         CNT_WIDTH  = 10,
   parameter int         MAX_PERIOD = 1023,
   parameter logic [7:0] MIN_AMP    = 8'h20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_valid,
   input  logic [7:0]           sample,
   output logic                 result_valid,
   output logic [CNT_WIDTH-1:0] period,
   output logic [7:0]           amplitude,
   output logic                 timeout,
   output logic                 locked
);

   localparam int HI_I = int'(MID) + int'(HYST);
   localparam int LO_I = int'(MID) - int'(HYST);
   localparam logic [7:0] TH_HI = 8'((HI_I > 255) ? 255 : HI_I);
   localparam logic [7:0] TH_LO = 8'((LO_I < 0) ? 0 : LO_I);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_PERIOD - 1);

   typedef enum logic [1:0] {
      SEARCH,
      ARMED,
      HIGH_ST,
      LOW_ST
   } state_t;

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [7:0]           max_r, max_n;
   logic [7:0]           min_r, min_n;
   logic [CNT_WIDTH-1:0] period_n;
   logic [7:0]           amp_n;
   logic                 locked_n;
   logic                 rv_n;
   logic                 to_n;

   logic       is_hi;
   logic       is_lo;
   logic [7:0] mx_s;
   logic [7:0] mn_s;
   logic [7:0] amp_c;

   assign is_hi = (sample >= TH_HI);
   assign is_lo = (sample <= TH_LO);
   assign mx_s  = (sample > max_r) ? sample : max_r;
   assign mn_s  = (sample < min_r) ? sample : min_r;
   assign amp_c = mx_s - mn_s;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      max_n    = max_r;
      min_n    = min_r;
      period_n = period;
      amp_n    = amplitude;
      locked_n = locked;
      rv_n     = 1'b0;
      to_n     = 1'b0;
      if (sample_valid) begin
         unique case (state)
            SEARCH: begin
               if (is_lo) state_n = ARMED;
            end
            ARMED: begin
               if (is_hi) begin
                  state_n = HIGH_ST;
                  cnt_n   = '0;
                  max_n   = sample;
                  min_n   = sample;
               end
            end
            HIGH_ST, LOW_ST: begin
               if (state == LOW_ST && is_hi) begin
                  state_n  = HIGH_ST;
                  cnt_n    = '0;
                  max_n    = sample;
                  min_n    = sample;
                  period_n = cnt + 1'b1;
                  amp_n    = amp_c;
                  rv_n     = 1'b1;
                  locked_n = (amp_c >= MIN_AMP);
               end else if (cnt == CNT_LAST) begin
                  // loss of signal: measurement values are kept
                  state_n  = SEARCH;
                  cnt_n    = '0;
                  to_n     = 1'b1;
                  locked_n = 1'b0;
               end else begin
                  cnt_n = cnt + 1'b1;
                  max_n = mx_s;
                  min_n = mn_s;
                  if (state == HIGH_ST && is_lo) state_n = LOW_ST;
               end
            end
            default: state_n = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= SEARCH;
         cnt          <= '0;
         max_r        <= '0;
         min_r        <= '0;
         period       <= '0;
         amplitude    <= '0;
         locked       <= 1'b0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         max_r        <= max_n;
         min_r        <= min_n;
         period       <= period_n;
         amplitude    <= amp_n;
         locked       <= locked_n;
         result_valid <= rv_n;
         timeout      <= to_n;
      end
   end

endmodule

// File: tb/tb_sine_period_detector.sv
// Scoreboard bench for sine_period_detector: stimulus feeds a window-based
// reference model, a negedge monitor pops and checks every output pulse.
module tb_sine_period_detector;

   localparam int TH_HI = 8'h58;
   localparam int TH_LO = 8'h48;
   localparam int MAXP  = 1023;
   localparam int MINA  = 8'h20;

   logic       clk;
   logic       rst;
   logic       sample_valid;
   logic [7:0] sample;
   logic       result_valid;
   logic [9:0] period;
   logic [7:0] amplitude;
   logic       timeout;
   logic       locked;

   sine_period_detector dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample),
      .result_valid (result_valid),
      .period       (period),
      .amplitude    (amplitude),
      .timeout      (timeout),
      .locked       (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_to;
      int per;
      int amp;
      bit lk;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sine[32];

   // reference model: samples since the last rising crossing kept in a window
   bit   m_armed;
   bit   m_track;
   bit   m_was_low;
   int   m_win[$];
   bit   m_locked;
   int   m_per;
   int   m_amp;

   function automatic void chk(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endfunction

   function automatic void model_reset();
      m_armed   = 0;
      m_track   = 0;
      m_was_low = 0;
      m_win.delete();
      m_locked  = 0;
      m_per     = 0;
      m_amp     = 0;
   endfunction

   function automatic void model_step(int s);
      bit   hi;
      bit   lo;
      int   mx;
      int   mn;
      exp_t e;
      hi = (s >= TH_HI);
      lo = (s <= TH_LO);
      if (!m_track) begin
         if (!m_armed) begin
            if (lo) m_armed = 1;
         end else if (hi) begin
            m_track   = 1;
            m_was_low = 0;
            m_win     = {s};
         end
      end else if (hi && m_was_low) begin
         mx = s;
         mn = s;
         foreach (m_win[i]) begin
            if (m_win[i] > mx) mx = m_win[i];
            if (m_win[i] < mn) mn = m_win[i];
         end
         m_per     = m_win.size();
         m_amp     = mx - mn;
         m_locked  = (m_amp >= MINA);
         e         = '{0, m_per, m_amp, m_locked};
         q.push_back(e);
         m_win     = {s};
         m_was_low = 0;
      end else if (m_win.size() == MAXP) begin
         m_locked = 0;
         e        = '{1, m_per, m_amp, 0};
         q.push_back(e);
         m_track  = 0;
         m_armed  = 0;
         m_win.delete();
      end else begin
         m_win.push_back(s);
         if (lo) m_was_low = 1;
      end
   endfunction

   task automatic drive(int s, bit v);
      @(posedge clk);
      #1;
      sample_valid = v;
      sample       = 8'(s);
      if (v) model_step(s);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0);
   endtask

   task automatic do_reset();
      idle(3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_period", int'(period), 0);
      chk("rst_amplitude", int'(amplitude), 0);
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_locked", int'(locked), 0);
      model_reset();
      q.delete();
      idle(2);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (result_valid || timeout)) begin
         if (result_valid && timeout) chk("pulse_exclusive", 1, 0);
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            e = q.pop_front();
            chk("pulse_kind_timeout", int'(timeout), int'(e.is_to));
            chk("period", int'(period), e.per);
            chk("amplitude", int'(amplitude), e.amp);
            chk("locked", int'(locked), int'(e.lk));
         end
      end
   end

   initial begin
      int tri_v[20];
      int nar_v[20];
      for (int k = 0; k < 32; k++)
         sine[k] = 80 + int'(64.0 * $sin(2.0 * 3.14159265358979 * k / 32.0));
      for (int i = 0; i < 10; i++) begin
         tri_v[i]      = 68 + (24 * i + 5) / 10;
         tri_v[10 + i] = 92 - (24 * i + 5) / 10;
         nar_v[i]      = 74 + (12 * i) / 10;
         nar_v[10 + i] = 86 - (12 * i) / 10;
      end
      model_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample       = 8'h00;
      #3;
      chk("init_period", int'(period), 0);
      chk("init_amplitude", int'(amplitude), 0);
      chk("init_locked", int'(locked), 0);
      chk("init_result_valid", int'(result_valid), 0);
      chk("init_timeout", int'(timeout), 0);
      idle(2);
      rst = 1'b0;

      for (int n = 0; n < 5 * 32; n++) drive(sine[n % 32], 1);
      idle(2);
      chk("sine32_period", int'(period), 32);
      chk("sine32_amplitude", int'(amplitude), 8'h80);
      chk("sine32_locked", int'(locked), 1);

      for (int n = 0; n < 5 * 16; n++) drive(sine[(2 * n) % 32], 1);
      idle(2);
      chk("sine16_period", int'(period), 16);
      chk("sine16_amplitude", int'(amplitude), 8'h80);

      for (int n = 0; n < 4 * 32; n++) begin
         drive(sine[n % 32], 1);
         drive(8'hff, 0);
      end
      idle(2);
      chk("toggle_period", int'(period), 32);

      for (int n = 0; n < 1100; n++) drive(8'h50, 1);
      idle(2);
      chk("timeout_period_held", int'(period), 32);
      chk("timeout_amp_held", int'(amplitude), 8'h80);
      chk("timeout_locked", int'(locked), 0);

      for (int n = 0; n < 5 * 20; n++) drive(tri_v[n % 20], 1);
      idle(2);
      chk("tri_period", int'(period), 20);
      chk("tri_amplitude", int'(amplitude), 8'h18);
      chk("tri_locked", int'(locked), 0);

      do_reset();
      for (int n = 0; n < 1200; n++) drive(nar_v[n % 20], 1);
      idle(2);
      chk("narrow_no_result", int'(period), 0);

      do_reset();
      for (int n = 0; n < 5; n++) drive(8'h90, 1);
      for (int n = 0; n < 4 * 32; n++) drive(sine[(n + 8) % 32], 1);
      idle(2);

      for (int n = 0; n < 300; n++)
         drive(sine[n % 32], ($urandom_range(0, 3) != 0));
      idle(2);
      chk("pre_reset_locked", int'(locked), int'(m_locked));
      do_reset();
      for (int n = 0; n < 3 * 32; n++) drive(sine[n % 32], 1);

      for (int n = 0; n < 3000; n++)
         drive($urandom_range(0, 255), ($urandom_range(0, 3) != 0));
      for (int n = 0; n < 1500; n++) begin
         int s;
         s = sine[n % 32] + $urandom_range(0, 6) - 3;
         drive(s, ($urandom_range(0, 4) != 0));
      end
      idle(4);
      chk("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
